// File: rtl/maxnet_pkg.sv
// Shared Maxnet constants: word geometry, loader state encoding and FP32 weights.
package maxnet_pkg;
   localparam int WORD_W   = 32;
   localparam int N_INPUTS = 4;

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2
   } loader_state_t;

   localparam logic [31:0] ONE = 32'h3F800000;
   localparam logic [31:0] EPS = 32'hBE4CCCCD;
endpackage

// File: rtl/word_regfile.sv
// N-word store: one synchronous write port with synchronous clear, one combinational read port.
import maxnet_pkg::*;

module word_regfile #(
   parameter int WORD_W = maxnet_pkg::WORD_W,
   parameter int DEPTH  = maxnet_pkg::N_INPUTS,
   parameter int ADDR_W = $clog2(maxnet_pkg::N_INPUTS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);
   logic [DEPTH-1:0][WORD_W-1:0] mem;

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      always_ff @(posedge clk) begin
         if (rst)
            mem[i] <= '0;
         else if (we && waddr == ADDR_W'(i))
            mem[i] <= wdata;
      end
   end

   // Reads see the pre-edge contents, so a same-cycle write is visible only next cycle.
   assign rdata = mem[raddr];
endmodule

// File: rtl/maxnet_input_loader.sv
// Maxnet input memory writer: collects N_INPUTS stream words, pulses start, waits for done.
import maxnet_pkg::*;

module maxnet_input_loader #(
   parameter int WORD_W   = maxnet_pkg::WORD_W,
   parameter int N_INPUTS = maxnet_pkg::N_INPUTS,
   parameter int ADDR_W   = $clog2(maxnet_pkg::N_INPUTS),
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] address,
   output logic [WORD_W-1:0] read_data,
   output logic              start,
   input  logic              done,
   output logic              busy,
   output logic [CNT_W-1:0]  frame_cnt
);
   loader_state_t     state, state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic              accept, last_word;

   assign accept    = in_valid && in_ready;
   assign last_word = (wr_ptr == ADDR_W'(N_INPUTS - 1));

   always_ff @(posedge clk) begin
      if (rst)
         state <= FILL;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (accept && last_word) state_nxt = LAUNCH;
         LAUNCH:  state_nxt = RUN;
         RUN:     if (done) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      start    = 1'b0;
      busy     = 1'b0;
      case (state)
         FILL:    in_ready = !rst;
         LAUNCH:  begin start = 1'b1; busy = 1'b1; end
         RUN:     busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         frame_cnt <= '0;
      end else begin
         if (accept)
            wr_ptr <= last_word ? '0 : wr_ptr + 1'b1;
         // RUN is left on the first done edge, so a held done counts once.
         if (state == RUN && done)
            frame_cnt <= frame_cnt + 1'b1;
      end
   end

   // accept already implies FILL, which keeps the store locked while Maxnet reads it.
   word_regfile #(
      .WORD_W (WORD_W),
      .DEPTH  (N_INPUTS),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (address),
      .rdata (read_data)
   );
endmodule
